led_fade_module: RTL and testbench

LED_FADE_MODULE -- requirements
Module: led_fade_module

---
 rtl/led_fade_module.sv | 124 ++++++++++++
 tb/tb_led_fade_module.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_module.sv
// led_fade_module: ramps an LED between off and fully lit, following the
// on/off level from the blink stage. A 28-bit step counter paces the 8-bit
// duty ramp, and a free-running 8-bit counter turns the duty into PWM.
module led_fade_module #(
  parameter logic [27:0] STEP_CYCLES = 28'd195_312,
  parameter bit          ACTIVE_HIGH = 1'b1
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       LED_In,
  output logic       LED_Out,
  output logic [7:0] Duty_Out,
  output logic       Busy,
  output logic       Fade_Done
);

  typedef enum logic [1:0] {
    S_OFF       = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_ON        = 2'd2,
    S_RAMP_DOWN = 2'd3
  } state_e;

  localparam logic [7:0] DUTY_MAX = 8'hFF;
  localparam logic [7:0] DUTY_MIN = 8'h00;

  state_e      state_q,     state_d;
  logic [7:0]  duty_q,      duty_d;
  logic [27:0] step_cnt_q,  step_cnt_d;
  logic [7:0]  pwm_cnt_q,   pwm_cnt_d;
  logic        r_in_q,      r_in_d;
  logic        lit_q,       lit_d;
  logic        busy_q,      busy_d;
  logic        fade_done_q, fade_done_d;

  logic step_tick;

  // A duty step is due once the counter has spent STEP_CYCLES cycles.
  assign step_tick = (step_cnt_q == (STEP_CYCLES - 28'd1));

  // Next-state, duty, step pacing and the registered status outputs.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves it unassigned and no latch can be inferred.
    state_d     = state_q;
    duty_d      = duty_q;
    step_cnt_d  = 28'd0;
    fade_done_d = 1'b0;
    r_in_d      = LED_In;
    pwm_cnt_d   = pwm_cnt_q + 8'd1;
    lit_d       = (duty_q == DUTY_MAX) || (pwm_cnt_q < duty_q);

    unique case (state_q)
      S_OFF: begin
        if (r_in_q) state_d = S_RAMP_UP;
      end
      S_ON: begin
        if (!r_in_q) state_d = S_RAMP_DOWN;
      end
      S_RAMP_UP: begin
        // A reversal wins over a coincident step: duty holds, counter clears.
        if (!r_in_q) begin
          state_d = S_RAMP_DOWN;
        end else if (step_tick) begin
          duty_d = (duty_q == DUTY_MAX) ? DUTY_MAX : duty_q + 8'd1;
          if (duty_d == DUTY_MAX) begin
            state_d     = S_ON;
            fade_done_d = 1'b1;
          end
        end else begin
          step_cnt_d = step_cnt_q + 28'd1;
        end
      end
      S_RAMP_DOWN: begin
        if (r_in_q) begin
          state_d = S_RAMP_UP;
        end else if (step_tick) begin
          duty_d = (duty_q == DUTY_MIN) ? DUTY_MIN : duty_q - 8'd1;
          if (duty_d == DUTY_MIN) begin
            state_d     = S_OFF;
            fade_done_d = 1'b1;
          end
        end else begin
          step_cnt_d = step_cnt_q + 28'd1;
        end
      end
      default: state_d = S_OFF;
    endcase

    busy_d = (state_d == S_RAMP_UP) || (state_d == S_RAMP_DOWN);
  end

  // State and datapath registers; reset abandons any ramp in progress.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= S_OFF;
      duty_q      <= DUTY_MIN;
      step_cnt_q  <= 28'd0;
      pwm_cnt_q   <= 8'd0;
      r_in_q      <= 1'b0;
      lit_q       <= 1'b0;
      busy_q      <= 1'b0;
      fade_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the
      // pre-edge values, so the update order inside this block is irrelevant.
      state_q     <= state_d;
      duty_q      <= duty_d;
      step_cnt_q  <= step_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      r_in_q      <= r_in_d;
      lit_q       <= lit_d;
      busy_q      <= busy_d;
      fade_done_q <= fade_done_d;
    end
  end

  // Pin polarity; lit_q is 0 in reset, so the pin idles unlit either way.
  assign LED_Out   = ACTIVE_HIGH ? lit_q : ~lit_q;
  assign Duty_Out  = duty_q;
  assign Busy      = busy_q;
  assign Fade_Done = fade_done_q;

endmodule

// File: tb/tb_led_fade_module.sv
// Bench for led_fade_module with STEP_CYCLES=4, ACTIVE_HIGH=1. A timestamp
// model predicts duty as a clamped linear function of time since the last
// ramp start; directed steps plus a randomized phase are checked every cycle.
module tb_led_fade_module;

  localparam logic [27:0] STEP = 28'd4;
  localparam int          S    = 4;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       LED_In;
  logic       LED_Out;
  logic [7:0] Duty_Out;
  logic       Busy;
  logic       Fade_Done;

  always #5 CLK = ~CLK;

  led_fade_module #(.STEP_CYCLES(STEP), .ACTIVE_HIGH(1'b1)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .LED_In    (LED_In),
    .LED_Out   (LED_Out),
    .Duty_Out  (Duty_Out),
    .Busy      (Busy),
    .Fade_Done (Fade_Done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: direction of travel, ramp start time and start duty.
  int m_cyc, m_t0, m_d0, m_dir, m_duty, m_pwm;
  bit m_rin, m_done, m_lit;
  int fade_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rin = 1'b0; m_dir = 0; m_duty = 0; m_pwm = 0;
    m_lit = 1'b0; m_done = 1'b0; m_t0 = 0; m_d0 = 0;
  endtask

  task automatic model_edge();
    int want, steps, nd, endv;
    m_lit  = (m_duty == 255) || (m_pwm < m_duty);
    m_pwm  = (m_pwm + 1) % 256;
    m_done = 1'b0;
    m_cyc++;
    want = m_rin ? 1 : -1;
    if (m_dir == 0) begin
      if (m_rin && m_duty == 0) begin
        m_dir = 1; m_t0 = m_cyc; m_d0 = 0;
      end else if (!m_rin && m_duty == 255) begin
        m_dir = -1; m_t0 = m_cyc; m_d0 = 255;
      end
    end else if (want != m_dir) begin
      m_dir = want; m_t0 = m_cyc; m_d0 = m_duty;
    end else begin
      steps = (m_cyc - m_t0) / S;
      if (steps >= 1) begin
        nd = m_d0 + m_dir * steps;
        if (nd > 255) nd = 255;
        if (nd < 0) nd = 0;
        m_duty = nd;
        endv = (m_dir > 0) ? 255 : 0;
        if (nd == endv) begin
          m_dir = 0; m_done = 1'b1;
        end
      end
    end
    m_rin = LED_In;
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    if (Fade_Done === 1'b1) fade_cnt++;
    check("duty",      Duty_Out,  m_duty);
    check("busy",      Busy,      (m_dir != 0));
    check("fade_done", Fade_Done, m_done);
    check("led_out",   LED_Out,   m_lit);
  endtask

  task automatic wait_duty(input int target, input int budget, input string tag);
    int n = 0;
    while (Duty_Out !== target[7:0] && n < budget) begin
      tick();
      n++;
    end
    check(tag, Duty_Out, target);
  endtask

  initial begin
    int high, fades_before, hold;

    fade_cnt = 0;
    m_cyc    = 0;
    model_reset();
    RSTn   = 1'b0;
    LED_In = 1'b1;

    // Reset held for 5 cycles with LED_In high.
    repeat (5) @(negedge CLK);
    check("rst_led_out", LED_Out,   1'b0);
    check("rst_duty",    Duty_Out,  8'd0);
    check("rst_busy",    Busy,      1'b0);
    check("rst_fade",    Fade_Done, 1'b0);

    // Release: rIn after one edge, RAMP_UP after two.
    RSTn = 1'b1;
    tick();
    check("busy_edge1", Busy, 1'b0);
    tick();
    check("busy_edge2", Busy, 1'b1);

    // Full ramp up: 1020 cycles after entering RAMP_UP.
    for (int i = 0; i < 1020; i++) begin
      tick();
      if (i == 3) check("first_step", Duty_Out, 8'd1);
      if (i == 1018) check("pre_top", Duty_Out, 8'd254);
    end
    check("ramp_up_top",  Duty_Out,  8'd255);
    check("ramp_up_done", Fade_Done, 1'b1);
    check("ramp_up_busy", Busy,      1'b0);
    tick();
    high = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (LED_Out === 1'b1) high++;
    end
    check("on_led_constant", high, 300);
    check("fade_count_up", fade_cnt, 1);

    // Full ramp down from ON.
    LED_In = 1'b0;
    tick();
    tick();
    check("down_busy", Busy, 1'b1);
    for (int i = 0; i < 1020; i++) tick();
    check("ramp_down_bottom", Duty_Out,  8'd0);
    check("ramp_down_done",   Fade_Done, 1'b1);
    tick();
    high = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (LED_Out === 1'b1) high++;
    end
    check("pwm_duty0_high", high, 0);
    check("fade_count_down", fade_cnt, 2);

    // Reversal at duty 100: hold 100, then 99 four cycles later, no pulse.
    LED_In = 1'b1;
    wait_duty(100, 500, "reach_100");
    fades_before = fade_cnt;
    LED_In = 1'b0;
    tick();
    tick();
    check("rev_duty_hold", Duty_Out, 8'd100);
    check("rev_busy",      Busy,     1'b1);
    repeat (4) tick();
    check("rev_duty_99",  Duty_Out, 8'd99);
    check("rev_no_pulse", fade_cnt, fades_before);

    // Freeze duty at 64 by reversing every cycle, then measure one PWM period.
    wait_duty(64, 300, "reach_64");
    for (int i = 0; i < 4; i++) begin
      LED_In = ~LED_In;
      tick();
    end
    high = 0;
    for (int i = 0; i < 256; i++) begin
      LED_In = ~LED_In;
      tick();
      if (LED_Out === 1'b1) high++;
    end
    check("pwm_duty64_high", high, 64);
    check("pwm_duty64_hold", Duty_Out, 8'd64);

    // Reset mid ramp-up at duty 50.
    LED_In = 1'b0;
    wait_duty(40, 300, "reach_40");
    LED_In = 1'b1;
    wait_duty(50, 300, "reach_50");
    check("mid_busy", Busy, 1'b1);
    #2 RSTn = 1'b0;
    model_reset();
    #1;
    check("async_duty",    Duty_Out, 8'd0);
    check("async_busy",    Busy,     1'b0);
    check("async_led_out", LED_Out,  1'b0);
    @(negedge CLK);
    RSTn = 1'b1;
    tick();
    check("restart_busy1", Busy, 1'b0);
    tick();
    check("restart_busy2", Busy, 1'b1);
    repeat (4) tick();
    check("restart_duty1", Duty_Out, 8'd1);

    // Randomized phase: random levels held for random lengths.
    for (int seg = 0; seg < 24; seg++) begin
      LED_In = 1'($urandom_range(0, 1));
      hold   = (seg % 3 == 0) ? $urandom_range(1, 8) : $urandom_range(1, 400);
      for (int i = 0; i < hold; i++) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
